// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM encoding and sizing helpers.
// Latency: none (package only).
// Backpressure: none (package only).
package adder_pkg;

  // Two-bit FSM encoding for the slice-serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice counter width: enough to count K slices, never narrower than one bit.
  function automatic int cnt_width(input int k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction

  // Signed overflow of a two's-complement add, given both operand MSBs and the sum MSB.
  function automatic logic sum_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_cla.sv
// N-bit carry-lookahead adder (Kogge-Stone parallel prefix) with carry in/out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module adder_cla #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);

  // Prefix tree: after the loop g[i]/p[i] hold group generate/propagate over bits [i:0].
  always_comb begin
    logic [N-1:0] p0;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] g_nxt;
    logic [N-1:0] p_nxt;
    logic [N-1:0] ones;
    logic [N:0]   carry;
    p0    = a ^ b;
    g     = a & b;
    p     = p0;
    ones  = '1;
    g_nxt = '0;
    p_nxt = '0;
    for (int d = 1; d < N; d = d * 2) begin
      // Bits below d have no partner d places down; keep their propagate unchanged.
      g_nxt = g | (p & (g << d));
      p_nxt = p & ((p << d) | (ones >> (N - d)));
      g     = g_nxt;
      p     = p_nxt;
    end
    carry = {g | (p & {N{ci}}), ci};
    sum   = p0 ^ carry[N-1:0];
    co    = carry[N];
  end

endmodule

// File: rtl/adder_serial.sv
// Slice-serial W-bit adder: one N-bit carry-lookahead slice per cycle, K = W/N slices.
// Latency: K cycles in RUN after the accepting edge, then result held in DONE.
// Backpressure: in_ready only in IDLE; DONE holds s/co/ovf until out_ready.
module adder_serial
  import adder_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ovf,
  output logic         busy
);

  localparam int K  = (N < 1) ? 1 : W / N;
  localparam int CW = cnt_width(K);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  // Reject slice widths that do not tile the operand exactly.
  if (N < 1) begin : g_bad_n
    $error("adder_serial: slice width N must be at least 1");
  end else if (W % N != 0) begin : g_bad_w
    $error("adder_serial: operand width W must be a multiple of slice width N");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  res_q, res_d;
  logic          cy_q, cy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          amsb_q, amsb_d;
  logic          bmsb_q, bmsb_d;
  logic [W-1:0]  s_q, s_d;
  logic          co_q, co_d;
  logic          ovf_q, ovf_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  slice_sum;
  logic          slice_co;
  logic [W-1:0]  res_shift;

  // Low slice of each operand plus the running carry.
  adder_cla #(.N(N)) u_cla (
    .a   (opa_q[N-1:0]),
    .b   (opb_q[N-1:0]),
    .ci  (cy_q),
    .sum (slice_sum),
    .co  (slice_co)
  );

  // New slice enters at the MSB end; after K slices the first one sits at the LSB.
  assign res_shift = W'({slice_sum, res_q} >> N);

  // Next-state and datapath update for all registers.
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    cy_d        = cy_q;
    cnt_d       = cnt_q;
    amsb_d      = amsb_q;
    bmsb_d      = bmsb_q;
    s_d         = s_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b;
          cy_d    = ci;
          cnt_d   = '0;
          amsb_d  = a[W-1];
          bmsb_d  = b[W-1];
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d = opa_q >> N;
        opb_d = opb_q >> N;
        res_d = res_shift;
        cy_d  = slice_co;
        if (cnt_q == CNT_LAST) begin
          // Last slice: publish the result; counter holds so it never wraps.
          s_d         = res_shift;
          co_d        = slice_co;
          ovf_d       = sum_ovf(amsb_q, bmsb_q, res_shift[W-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          s_d         = '0;
          co_d        = 1'b0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        s_d         = '0;
        co_d        = 1'b0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State register bank; reset clears everything and abandons any operation in flight.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      amsb_q      <= 1'b0;
      bmsb_q      <= 1'b0;
      s_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      cy_q        <= cy_d;
      cnt_q       <= cnt_d;
      amsb_q      <= amsb_d;
      bmsb_q      <= bmsb_d;
      s_q         <= s_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_serial.sv
// Scoreboard bench for adder_serial: W=32 with N=8 (K=4) and N=32 (K=1) instances.
// Directed corner cases, backpressure and reset on the K=4 instance, then random traffic on both.
module tb_adder_serial;

  logic        clk;
  logic        rstb;
  logic        iv   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [31:0] av   [2];
  logic [31:0] bv   [2];
  logic        civ  [2];
  logic [31:0] sv   [2];
  logic        cov  [2];
  logic        ovfv [2];
  logic        bz   [2];
  bit          rdone [2];

  logic [33:0] q0 [$];
  logic [33:0] q1 [$];
  int n_cmp;
  int n_bad;

  adder_serial #(.W(32), .N(8)) dut (
    .clk(clk), .rstb(rstb), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .ci(civ[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .s(sv[0]), .co(cov[0]),
    .ovf(ovfv[0]), .busy(bz[0])
  );

  adder_serial #(.W(32), .N(32)) dut_k1 (
    .clk(clk), .rstb(rstb), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .ci(civ[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .s(sv[1]), .co(cov[1]),
    .ovf(ovfv[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-width add, result packed as {co, ovf, s}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {32'b0, c};
    v = (x[31] == y[31]) && (t[31] != x[31]);
    return {t[32], v, t[31:0]};
  endfunction

  task automatic mon(input int u);
    logic [33:0] e;
    if (iv[u] && ir[u]) begin
      if (u == 0) q0.push_back(model(av[u], bv[u], civ[u]));
      else        q1.push_back(model(av[u], bv[u], civ[u]));
    end
    if (ov[u] && ordy[u]) begin
      e = 'x;
      if (u == 0) begin
        if (q0.size() != 0) e = q0.pop_front();
      end else begin
        if (q1.size() != 0) e = q1.pop_front();
      end
      chk($sformatf("u%0d_result", u), {cov[u], ovfv[u], sv[u]}, e);
    end
    if (!ov[u]) chk($sformatf("u%0d_zero_when_invalid", u), {cov[u], ovfv[u], sv[u]}, 0);
  endtask

  always @(negedge clk) begin
    if (rstb) begin
      mon(0);
      mon(1);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic accept(input int u, input logic [31:0] x, input logic [31:0] y, input logic c);
    int t;
    av[u]  = x;
    bv[u]  = y;
    civ[u] = c;
    iv[u]  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ir[u] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("u%0d_accept", u), ir[u], 1);
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
  endtask

  // Edges counted from the accepting edge (inclusive) to the edge raising out_valid.
  task automatic lat_op(input int u, input logic [31:0] x, input logic [31:0] y, input logic c,
                        input int k);
    int lat;
    ordy[u] = 1'b0;
    accept(u, x, y, c);
    lat = 1;
    chk($sformatf("u%0d_busy_after_accept", u), bz[u], 1);
    chk($sformatf("u%0d_in_ready_low", u), ir[u], 0);
    while (!ov[u] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("u%0d_latency", u), lat, k + 1);
  endtask

  task automatic chk_out(input string tag, input int u, input logic [31:0] es, input logic eco,
                         input logic eovf);
    chk({tag, "_s"}, sv[u], es);
    chk({tag, "_co"}, cov[u], eco);
    chk({tag, "_ovf"}, ovfv[u], eovf);
  endtask

  task automatic release_out(input int u);
    ordy[u] = 1'b1;
    @(posedge clk);
    #1;
    ordy[u] = 1'b0;
    chk($sformatf("u%0d_released", u), ov[u], 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_ops(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      accept(u, pick(), pick(), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic rand_ready(input int u);
    while (!rdone[u]) begin
      @(posedge clk);
      #1;
      ordy[u] = ($urandom_range(0, 3) != 0);
    end
    ordy[u] = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    n_cmp = 0;
    n_bad = 0;
    rstb  = 1'b0;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b0; av[u] = '0; bv[u] = '0; civ[u] = 1'b0; rdone[u] = 1'b0;
    end
    #3;
    chk("reset_in_ready", ir[0], 1);
    chk("reset_out_valid", ov[0], 0);
    chk("reset_busy", bz[0], 0);
    chk("reset_outputs", {cov[0], ovfv[0], sv[0]}, 0);
    chk("reset_k1_in_ready", ir[1], 1);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    lat_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4);
    chk_out("carry_ripple", 0, 32'h0000_0000, 1'b1, 1'b0);
    release_out(0);
    lat_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4);
    chk_out("pos_ovf", 0, 32'h8000_0000, 1'b0, 1'b1);
    release_out(0);
    lat_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 4);
    chk_out("neg_ovf", 0, 32'h0000_0000, 1'b1, 1'b1);
    release_out(0);

    // Backpressure: result must hold and in_valid must be ignored while DONE.
    lat_op(0, 32'hA5A5_0F0F, 32'h1234_5678, 1'b0, 4);
    for (int i = 0; i < 6; i++) begin
      iv[0] = (i % 2 == 0);
      av[0] = $urandom;
      bv[0] = $urandom;
      @(posedge clk);
      #1;
      chk("bp_out_valid", ov[0], 1);
      chk("bp_s", sv[0], 32'hB7D9_6587);
      chk("bp_co", cov[0], 0);
      chk("bp_in_ready", ir[0], 0);
    end
    iv[0] = 1'b0;
    release_out(0);
    chk("bp_idle_in_ready", ir[0], 1);
    chk("bp_idle_s", sv[0], 0);

    // Reset during the second RUN cycle abandons the operation.
    accept(0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
    @(posedge clk);
    #1;
    rstb = 1'b0;
    #1;
    chk("rst_out_valid", ov[0], 0);
    chk("rst_in_ready", ir[0], 1);
    chk("rst_busy", bz[0], 0);
    chk("rst_outputs", {cov[0], ovfv[0], sv[0]}, 0);
    q0.delete();
    @(negedge clk);
    rstb = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("rst_no_result", ov[0], 0);
    end
    lat_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 4);
    chk_out("after_rst", 0, 32'h2345_6789, 1'b0, 1'b0);
    release_out(0);

    // K = 1 build: single RUN cycle.
    lat_op(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
    chk_out("k1_carry", 1, 32'h0000_0000, 1'b1, 1'b0);
    release_out(1);
    lat_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
    chk_out("k1_ovf", 1, 32'h8000_0000, 1'b0, 1'b1);
    release_out(1);

    fork
      begin rand_ops(0, 1000); rdone[0] = 1'b1; end
      begin rand_ops(1, 1000); rdone[1] = 1'b1; end
      rand_ready(0);
      rand_ready(1);
    join

    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("drain_k4", q0.size(), 0);
    chk("drain_k1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_serial.md
ADDER_SERIAL -- requirements
Module: adder_serial

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand and result width in bits.
REQ-002 SHALL have parameter N, default 8, meaning slice width added per cycle; K = W/N slice cycles.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rstb  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have in_valid  input  1  operands a, b, ci presented.
REQ-006 SHALL have in_ready  output  1  block can accept an operation.
REQ-007 SHALL have a  input  W  first operand.
REQ-008 SHALL have b  input  W  second operand.
REQ-009 SHALL have ci  input  1  carry-in of the operation.
REQ-010 SHALL have out_valid  output  1  result s, co, ovf valid.
REQ-011 SHALL have out_ready  input  1  consumer accepts result.
REQ-012 SHALL have s  output  W  sum (a + b + ci) mod 2^W.
REQ-013 SHALL have co  output  1  unsigned carry-out of the W-bit sum.
REQ-014 SHALL have ovf  output  1  two's-complement overflow of the W-bit sum.
REQ-015 SHALL have busy  output  1  high in RUN and DONE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; in_valid=1 at an edge captures a, b into operand shift registers, carry register <= ci, slice counter <= 0, a[W-1], b[W-1] latched, next state RUN.
REQ-018 RUN: each edge adds operand bits [N-1:0] plus carry register, shifts the N-bit slice sum into result register from the MSB end, shifts operands right by N, carry register <= slice carry-out, counter increments.
REQ-019 RUN SHALL last exactly K edges; at the edge where counter == K-1 next state is DONE.
REQ-020 out_valid SHALL rise exactly K+1 edges after the accepting edge; in_ready low from the accepting edge until return to IDLE.
REQ-021 DONE: out_valid=1, s/co/ovf stable; out_valid&out_ready at an edge -> IDLE; out_ready low holds DONE indefinitely.
REQ-022 in_valid while not IDLE SHALL be ignored and SHALL NOT alter state or result.
REQ-023 co SHALL equal final carry register; ovf = (latched a msb == latched b msb) & (s[W-1] != latched a msb).
REQ-024 s, co, ovf SHALL be 0 whenever out_valid is 0.
REQ-025 K == 1 (N == W) SHALL be legal: single RUN cycle.
REQ-026 Elaboration SHALL fail if W % N != 0 or N < 1.
REQ-027 Counter width SHALL be max(1, clog2(K)); no wrap in normal operation.

Reset
REQ-028 rstb low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, s=0, co=0, ovf=0, all internal registers 0.
REQ-029 Reset mid-RUN or mid-DONE SHALL abandon the operation with no result emitted.
REQ-030 First accept after rstb deassertion SHALL occur no earlier than the first rising edge with rstb high.

Structure
REQ-031 State encodings (IDLE=0, RUN=1, DONE=2, 2-bit) SHALL live in shared package adder_pkg.
REQ-032 Per-cycle slice addition SHALL be one instance of the team's N-bit adder_cla; no other arithmetic submodule.
REQ-033 Outputs SHALL be driven from registers; no combinational path from in_valid/out_ready to outputs except in_ready decode from state.

Verification (W=32, N=8)
REQ-034 a=0xFFFFFFFF, b=0, ci=1 -> out_valid 5 edges after accept, s=0x00000000, co=1, ovf=0.
REQ-035 a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, ovf=1; a=0x80000000, b=0x80000000 -> s=0, co=1, ovf=1.
REQ-036 Backpressure: out_ready low 6 cycles in DONE -> s, co, out_valid held; in_valid pulses meanwhile ignored; next op accepted only after handshake.
REQ-037 rstb pulsed low during RUN cycle 2 -> outputs 0 immediately, IDLE, no out_valid; following op 0x12345678+0x11111111 -> s=0x23456789.
REQ-038 Random 1000 ops with random in_valid/out_ready stalls, also N=32 (K=1) build -> s/co/ovf match reference model, one result per accepted op in order.
